// File: rtl/flow_sequencer.sv
// flow_sequencer: program counter and instruction sequencing.
// Resolves flow opcodes, waits on datapath ops, and parks in TRAP.
module flow_sequencer #(
   parameter int                    PC_WIDTH  = 20,
   parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
   parameter int                    CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic                 fetch_req,
   output logic [PC_WIDTH-1:0]  fetch_addr,
   input  logic                 fetch_ack,
   input  logic [2:0]           flow_op,
   input  logic [PC_WIDTH-1:0]  rel_addr,
   input  logic                 zero_flag,
   input  logic                 sign_flag,
   input  logic                 exec_done,
   input  logic                 trap_mode,
   input  logic                 trap_clear,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 branch_taken,
   output logic                 trap_active,
   output logic [CNT_WIDTH-1:0] retire_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      TRAP  = 2'd3
   } state_t;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_JMP   = 3'b001;
   localparam logic [2:0] OP_JMPZ  = 3'b010;
   localparam logic [2:0] OP_JMPS  = 3'b011;
   localparam logic [2:0] OP_JMPZS = 3'b100;
   localparam logic [2:0] OP_TRAP  = 3'b101;

   state_t                state;
   state_t                state_nxt;
   logic [PC_WIDTH-1:0]   pc_nxt;
   logic                  retire;
   logic                  taken;
   logic                  cond;
   logic                  is_dp;

   // Branch condition for the opcode presented with fetch_ack.
   always_comb begin
      cond  = 1'b0;
      is_dp = (flow_op[2:1] == 2'b11);
      case (flow_op)
         OP_JMP:   cond = 1'b1;
         OP_JMPZ:  cond = zero_flag;
         OP_JMPS:  cond = sign_flag;
         OP_JMPZS: cond = zero_flag & sign_flag;
         OP_NOP,
         OP_TRAP:  cond = 1'b0;
         default:  cond = 1'b0;
      endcase
   end

   // Next-state, next-pc and retire decode.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      retire    = 1'b0;
      taken     = 1'b0;
      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            if (fetch_ack) begin
               if (is_dp) begin
                  state_nxt = EXEC;
               end else begin
                  retire = 1'b1;
                  taken  = cond;
                  pc_nxt = cond ? pc + rel_addr : pc + 1'b1;
                  if (flow_op == OP_TRAP || trap_mode)
                     state_nxt = TRAP;
                  else
                     state_nxt = FETCH;
               end
            end
         end
         EXEC: begin
            if (exec_done) begin
               retire    = 1'b1;
               pc_nxt    = pc + 1'b1;
               state_nxt = trap_mode ? TRAP : FETCH;
            end
         end
         TRAP: begin
            if (trap_clear)
               state_nxt = FETCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, pc, retire counter and taken pulse registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         retire_count <= '0;
         branch_taken <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         branch_taken <= taken;
         if (retire)
            retire_count <= retire_count + 1'b1;
      end
   end

   assign fetch_req   = (state == FETCH);
   assign trap_active = (state == TRAP);
   assign fetch_addr  = pc;

endmodule

// File: tb/tb_flow_sequencer.sv
// tb_flow_sequencer: directed tests for flow_sequencer.
// Each task drives one scenario and checks hand-computed values.
module tb_flow_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_req;
   logic [19:0] fetch_addr;
   logic        fetch_ack = 1'b0;
   logic [2:0]  flow_op = 3'b000;
   logic [19:0] rel_addr = '0;
   logic        zero_flag = 1'b0;
   logic        sign_flag = 1'b0;
   logic        exec_done = 1'b0;
   logic        trap_mode = 1'b0;
   logic        trap_clear = 1'b0;
   logic [19:0] pc;
   logic        branch_taken;
   logic        trap_active;
   logic [15:0] retire_count;

   int n_checks = 0;
   int n_fail   = 0;

   flow_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_ack    (fetch_ack),
      .flow_op      (flow_op),
      .rel_addr     (rel_addr),
      .zero_flag    (zero_flag),
      .sign_flag    (sign_flag),
      .exec_done    (exec_done),
      .trap_mode    (trap_mode),
      .trap_clear   (trap_clear),
      .pc           (pc),
      .branch_taken (branch_taken),
      .trap_active  (trap_active),
      .retire_count (retire_count)
   );

   always #5 clock = ~clock;

   task automatic do_reset;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic ack(input logic [2:0] op, input logic [19:0] rel,
                      input logic z, input logic s);
      @(negedge clock);
      fetch_ack = 1'b1;
      flow_op   = op;
      rel_addr  = rel;
      zero_flag = z;
      sign_flag = s;
      @(posedge clock);
      #1;
      fetch_ack = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      ack(3'b001, 20'h00007, 1'b0, 1'b0);
      if (pc !== 20'h00007) begin
         $display("FAIL rst_pre_pc: got %h want %h", pc, 20'h00007);
         n_fail++;
      end
      n_checks++;
      @(negedge clock);
      reset = 1'b1;
      #1;
      if (pc !== 20'h00000) begin
         $display("FAIL rst_pc: got %h want %h", pc, 20'h0);
         n_fail++;
      end
      n_checks++;
      if (fetch_req !== 1'b0) begin
         $display("FAIL rst_req: got %b want 0", fetch_req);
         n_fail++;
      end
      n_checks++;
      if (branch_taken !== 1'b0 || trap_active !== 1'b0) begin
         $display("FAIL rst_flags: got %b%b want 00",
                  branch_taken, trap_active);
         n_fail++;
      end
      n_checks++;
      if (retire_count !== 16'h0000) begin
         $display("FAIL rst_cnt: got %h want 0", retire_count);
         n_fail++;
      end
      n_checks++;
      @(negedge clock);
      reset = 1'b0;
      #1;
      if (fetch_req !== 1'b0) begin
         $display("FAIL rst_idle_req: got %b want 0", fetch_req);
         n_fail++;
      end
      n_checks++;
      @(posedge clock);
      #1;
      if (fetch_req !== 1'b1 || fetch_addr !== 20'h00000) begin
         $display("FAIL rst_start: got req=%b addr=%h want 1/00000",
                  fetch_req, fetch_addr);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_jmp;
      do_reset();
      ack(3'b001, 20'h00005, 1'b0, 1'b0);
      ack(3'b001, 20'h00010, 1'b0, 1'b0);
      if (fetch_addr !== 20'h00015) begin
         $display("FAIL jmp_addr: got %h want %h", fetch_addr, 20'h15);
         n_fail++;
      end
      n_checks++;
      if (branch_taken !== 1'b1 || fetch_req !== 1'b1) begin
         $display("FAIL jmp_pulse: got bt=%b req=%b want 1/1",
                  branch_taken, fetch_req);
         n_fail++;
      end
      n_checks++;
      if (retire_count !== 16'd2) begin
         $display("FAIL jmp_cnt: got %0d want 2", retire_count);
         n_fail++;
      end
      n_checks++;
      @(posedge clock);
      #1;
      if (branch_taken !== 1'b0 || fetch_addr !== 20'h00015) begin
         $display("FAIL jmp_pulse_end: got bt=%b addr=%h want 0/00015",
                  branch_taken, fetch_addr);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_cond;
      do_reset();
      ack(3'b001, 20'h00003, 1'b0, 1'b0);
      ack(3'b010, 20'hFFFFE, 1'b1, 1'b0);
      if (pc !== 20'h00001 || branch_taken !== 1'b1) begin
         $display("FAIL jmpz_taken: got pc=%h bt=%b want 00001/1",
                  pc, branch_taken);
         n_fail++;
      end
      n_checks++;
      ack(3'b001, 20'h00002, 1'b0, 1'b0);
      ack(3'b010, 20'hFFFFE, 1'b0, 1'b1);
      if (pc !== 20'h00004 || branch_taken !== 1'b0) begin
         $display("FAIL jmpz_not: got pc=%h bt=%b want 00004/0",
                  pc, branch_taken);
         n_fail++;
      end
      n_checks++;
      ack(3'b100, 20'h00020, 1'b1, 1'b0);
      if (pc !== 20'h00005 || branch_taken !== 1'b0) begin
         $display("FAIL jmpzs_not: got pc=%h bt=%b want 00005/0",
                  pc, branch_taken);
         n_fail++;
      end
      n_checks++;
      ack(3'b011, 20'h00010, 1'b0, 1'b1);
      if (pc !== 20'h00015 || branch_taken !== 1'b1) begin
         $display("FAIL jmps_taken: got pc=%h bt=%b want 00015/1",
                  pc, branch_taken);
         n_fail++;
      end
      n_checks++;
      ack(3'b011, 20'h00010, 1'b1, 1'b0);
      if (pc !== 20'h00016) begin
         $display("FAIL jmps_not: got pc=%h want 00016", pc);
         n_fail++;
      end
      n_checks++;
      ack(3'b100, 20'hFFFFE, 1'b1, 1'b1);
      if (pc !== 20'h00014 || branch_taken !== 1'b1) begin
         $display("FAIL jmpzs_taken: got pc=%h bt=%b want 00014/1",
                  pc, branch_taken);
         n_fail++;
      end
      n_checks++;
      ack(3'b001, 20'hFFFEB, 1'b0, 1'b0);
      if (pc !== 20'hFFFFF) begin
         $display("FAIL jmp_back: got pc=%h want FFFFF", pc);
         n_fail++;
      end
      n_checks++;
      ack(3'b001, 20'h00002, 1'b0, 1'b0);
      if (pc !== 20'h00001) begin
         $display("FAIL jmp_wrap: got pc=%h want 00001", pc);
         n_fail++;
      end
      n_checks++;
      ack(3'b000, 20'h00040, 1'b1, 1'b1);
      if (pc !== 20'h00002 || branch_taken !== 1'b0) begin
         $display("FAIL nop_flags: got pc=%h bt=%b want 00002/0",
                  pc, branch_taken);
         n_fail++;
      end
      n_checks++;
      if (retire_count !== 16'd11) begin
         $display("FAIL cond_cnt: got %0d want 11", retire_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_datapath;
      do_reset();
      ack(3'b001, 20'h00010, 1'b0, 1'b0);
      ack(3'b110, 20'h00033, 1'b1, 1'b1);
      if (fetch_req !== 1'b0 || pc !== 20'h00010) begin
         $display("FAIL dp_enter: got req=%b pc=%h want 0/00010",
                  fetch_req, pc);
         n_fail++;
      end
      n_checks++;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         fetch_ack = 1'b1;
         flow_op   = 3'b001;
         rel_addr  = 20'h00100;
         @(posedge clock);
         #1;
         fetch_ack = 1'b0;
         if (fetch_req !== 1'b0 || pc !== 20'h00010) begin
            $display("FAIL dp_stray_ack: got req=%b pc=%h want 0/00010",
                     fetch_req, pc);
            n_fail++;
         end
         n_checks++;
      end
      @(negedge clock);
      exec_done = 1'b1;
      @(posedge clock);
      #1;
      if (pc !== 20'h00011 || fetch_req !== 1'b1) begin
         $display("FAIL dp_done: got pc=%h req=%b want 00011/1",
                  pc, fetch_req);
         n_fail++;
      end
      n_checks++;
      if (retire_count !== 16'd2 || branch_taken !== 1'b0) begin
         $display("FAIL dp_cnt: got cnt=%0d bt=%b want 2/0",
                  retire_count, branch_taken);
         n_fail++;
      end
      n_checks++;
      @(posedge clock);
      #1;
      exec_done = 1'b0;
      if (pc !== 20'h00011 || retire_count !== 16'd2) begin
         $display("FAIL dp_stray_done: got pc=%h cnt=%0d want 00011/2",
                  pc, retire_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_trap;
      do_reset();
      ack(3'b001, 20'h00007, 1'b0, 1'b0);
      @(negedge clock);
      trap_mode = 1'b1;
      ack(3'b000, 20'h00000, 1'b0, 1'b0);
      trap_mode = 1'b0;
      if (pc !== 20'h00008 || trap_active !== 1'b1 || fetch_req !== 1'b0) begin
         $display("FAIL trap_enter: got pc=%h ta=%b req=%b want 00008/1/0",
                  pc, trap_active, fetch_req);
         n_fail++;
      end
      n_checks++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         fetch_ack = 1'b1;
         exec_done = 1'b1;
         flow_op   = 3'b001;
         rel_addr  = 20'h00050;
         @(posedge clock);
         #1;
         fetch_ack = 1'b0;
         exec_done = 1'b0;
         if (trap_active !== 1'b1 || fetch_req !== 1'b0
             || pc !== 20'h00008) begin
            $display("FAIL trap_hold: got ta=%b req=%b pc=%h want 1/0/00008",
                     trap_active, fetch_req, pc);
            n_fail++;
         end
         n_checks++;
      end
      @(negedge clock);
      trap_clear = 1'b1;
      @(posedge clock);
      #1;
      trap_clear = 1'b0;
      if (trap_active !== 1'b0 || fetch_req !== 1'b1
          || fetch_addr !== 20'h00008) begin
         $display("FAIL trap_clear: got ta=%b req=%b addr=%h want 0/1/00008",
                  trap_active, fetch_req, fetch_addr);
         n_fail++;
      end
      n_checks++;
      ack(3'b101, 20'h00040, 1'b1, 1'b1);
      if (pc !== 20'h00009 || trap_active !== 1'b1
          || branch_taken !== 1'b0) begin
         $display("FAIL trap_op: got pc=%h ta=%b bt=%b want 00009/1/0",
                  pc, trap_active, branch_taken);
         n_fail++;
      end
      n_checks++;
      @(negedge clock);
      trap_clear = 1'b1;
      trap_mode  = 1'b1;
      @(posedge clock);
      #1;
      trap_clear = 1'b0;
      if (fetch_req !== 1'b1 || trap_active !== 1'b0) begin
         $display("FAIL trap_clear_mode: got req=%b ta=%b want 1/0",
                  fetch_req, trap_active);
         n_fail++;
      end
      n_checks++;
      ack(3'b111, 20'h00000, 1'b0, 1'b0);
      @(negedge clock);
      exec_done = 1'b1;
      @(posedge clock);
      #1;
      exec_done = 1'b0;
      trap_mode = 1'b0;
      if (pc !== 20'h0000A || trap_active !== 1'b1) begin
         $display("FAIL trap_dp: got pc=%h ta=%b want 0000A/1",
                  pc, trap_active);
         n_fail++;
      end
      n_checks++;
      if (retire_count !== 16'd4) begin
         $display("FAIL trap_cnt: got %0d want 4", retire_count);
         n_fail++;
      end
      n_checks++;
      @(negedge clock);
      trap_clear = 1'b1;
      @(posedge clock);
      #1;
      trap_clear = 1'b0;
   endtask

   task automatic test_wrap;
      do_reset();
      @(negedge clock);
      fetch_ack = 1'b1;
      flow_op   = 3'b000;
      rel_addr  = 20'h00000;
      @(posedge clock);
      #1;
      if (fetch_req !== 1'b1 || fetch_addr !== 20'h00001) begin
         $display("FAIL b2b_first: got req=%b addr=%h want 1/00001",
                  fetch_req, fetch_addr);
         n_fail++;
      end
      n_checks++;
      repeat (65534) @(posedge clock);
      #1;
      if (retire_count !== 16'hFFFF) begin
         $display("FAIL wrap_full: got %h want FFFF", retire_count);
         n_fail++;
      end
      n_checks++;
      @(posedge clock);
      #1;
      fetch_ack = 1'b0;
      if (retire_count !== 16'h0000 || pc !== 20'h10000) begin
         $display("FAIL wrap_zero: got cnt=%h pc=%h want 0000/10000",
                  retire_count, pc);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_exec_reset;
      do_reset();
      ack(3'b001, 20'h00004, 1'b0, 1'b0);
      ack(3'b110, 20'h00000, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      if (fetch_req !== 1'b0 || pc !== 20'h00000
          || retire_count !== 16'd0) begin
         $display("FAIL xrst_async: got req=%b pc=%h cnt=%0d want 0/0/0",
                  fetch_req, pc, retire_count);
         n_fail++;
      end
      n_checks++;
      @(negedge clock);
      reset     = 1'b0;
      exec_done = 1'b1;
      @(posedge clock);
      #1;
      if (retire_count !== 16'd0 || pc !== 20'h00000
          || fetch_req !== 1'b1) begin
         $display("FAIL xrst_late_done: got cnt=%0d pc=%h req=%b want 0/0/1",
                  retire_count, pc, fetch_req);
         n_fail++;
      end
      n_checks++;
      @(posedge clock);
      #1;
      exec_done = 1'b0;
      if (retire_count !== 16'd0 || pc !== 20'h00000) begin
         $display("FAIL xrst_fetch_done: got cnt=%0d pc=%h want 0/0",
                  retire_count, pc);
         n_fail++;
      end
      n_checks++;
   endtask

   initial begin
      test_reset();
      test_jmp();
      test_cond();
      test_datapath();
      test_trap();
      test_wrap();
      test_exec_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
